// File: rtl/melodik_wr_sequencer.sv
`default_nettype none
// melodik_wr_sequencer: buffers Ondra parallel-port writes and replays them to the SN76489
// with a fixed wr_n low width and inter-write gap counted in psg_ce ticks.  Rev 1.0
module melodik_wr_sequencer #(
   parameter int DEPTH        = 4,
   parameter int WR_LOW_TICKS = 32,
   parameter int GAP_TICKS    = 4
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       psg_ce,
   input  logic       stb_n,
   input  logic [7:0] data_in,
   output logic       psg_wr_n,
   output logic [7:0] psg_data,
   output logic       psg_clk_en,
   output logic       fifo_full,
   output logic       fifo_empty,
   output logic       overflow,
   output logic       busy
);
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW        = AW + 1;
   localparam int MAX_TICKS = (WR_LOW_TICKS > GAP_TICKS) ? WR_LOW_TICKS : GAP_TICKS;
   localparam int TW        = $clog2(MAX_TICKS + 1);

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [TW-1:0] WR_LAST    = TW'(WR_LOW_TICKS - 1);
   localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      GAP    = 2'd3
   } state_t;

   state_t        state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [TW-1:0] tick;
   logic          stb_n_q;
   logic          avail_q;
   logic          push;
   logic          pop;
   logic          push_ok;

   // avail_q delays the non-empty flag so a freshly pushed byte is seen by IDLE one cycle later.
   assign push    = stb_n_q & ~stb_n;
   assign pop     = (state == IDLE) & avail_q & ~fifo_empty;
   assign push_ok = push & ((count != FULL_COUNT) | pop);

   always_comb begin
      count_next = count;
      case ({push_ok, pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (!reset && push_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         stb_n_q    <= 1'b1;
         avail_q    <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         fifo_full  <= 1'b0;
         fifo_empty <= 1'b1;
         overflow   <= 1'b0;
         psg_clk_en <= 1'b0;
      end else begin
         stb_n_q    <= stb_n;
         avail_q    <= ~fifo_empty;
         count      <= count_next;
         fifo_full  <= (count_next == FULL_COUNT);
         fifo_empty <= (count_next == '0);
         if (push_ok) begin
            wr_ptr     <= wr_ptr + AW'(1);
            psg_clk_en <= 1'b1;
         end
         if (push && !push_ok) begin
            overflow <= 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state    <= IDLE;
         psg_wr_n <= 1'b1;
         psg_data <= 8'h00;
         tick     <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  psg_data <= mem[rd_ptr];
                  state    <= SETUP;
                  busy     <= 1'b1;
               end
            end
            SETUP: begin
               state    <= STROBE;
               psg_wr_n <= 1'b0;
               tick     <= '0;
            end
            STROBE: begin
               if (psg_ce) begin
                  if (tick == WR_LAST) begin
                     psg_wr_n <= 1'b1;
                     tick     <= '0;
                     state    <= GAP;
                  end else begin
                     tick <= tick + TW'(1);
                  end
               end
            end
            GAP: begin
               if (psg_ce) begin
                  if (tick == GAP_LAST) begin
                     tick  <= '0;
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     tick <= tick + TW'(1);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               psg_wr_n <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_melodik_wr_sequencer.sv
`default_nettype none
// tb_melodik_wr_sequencer: table-driven and scoreboard bench for the Melodik PSG write sequencer.
module tb_melodik_wr_sequencer;
   localparam int DEPTH  = 4;
   localparam int WR_LOW = 32;
   localparam int GAP    = 4;

   logic       clk_sys = 1'b0;
   logic       reset   = 1'b1;
   logic       psg_ce  = 1'b0;
   logic       stb_n   = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       psg_wr_n;
   logic [7:0] psg_data;
   logic       psg_clk_en;
   logic       fifo_full;
   logic       fifo_empty;
   logic       overflow;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int writes_seen = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] data;
      logic       exp_accept;
      logic       exp_full;
      logic       exp_ovf;
   } vec_t;
   vec_t burst[6];

   melodik_wr_sequencer #(
      .DEPTH(DEPTH),
      .WR_LOW_TICKS(WR_LOW),
      .GAP_TICKS(GAP)
   ) dut (
      .clk_sys(clk_sys),
      .reset(reset),
      .psg_ce(psg_ce),
      .stb_n(stb_n),
      .data_in(data_in),
      .psg_wr_n(psg_wr_n),
      .psg_data(psg_data),
      .psg_clk_en(psg_clk_en),
      .fifo_full(fifo_full),
      .fifo_empty(fifo_empty),
      .overflow(overflow),
      .busy(busy)
   );

   initial forever #5 clk_sys = ~clk_sys;

   // psg_ce: one-cycle pulse on every second clk_sys cycle
   initial forever begin
      @(posedge clk_sys);
      #1 psg_ce = ~psg_ce;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: PSG write scoreboard, wr_n low width and gap in psg_ce ticks
   logic       prev_wr = 1'b1;
   logic       in_low = 1'b0;
   logic       have_prev = 1'b0;
   int         low_ce = 0;
   int         low_cyc = 0;
   int         gap_ce = 0;
   logic [7:0] cur_data = 8'h00;

   always @(negedge clk_sys) begin
      if (reset) begin
         prev_wr   = 1'b1;
         in_low    = 1'b0;
         have_prev = 1'b0;
      end else begin
         if (prev_wr && !psg_wr_n) begin
            if (have_prev) check("gap_ticks_min", (gap_ce >= GAP), 1);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL psg_write: actual unexpected write 0x%0h required none", psg_data);
            end else begin
               cur_data = exp_q.pop_front();
               if (psg_data !== cur_data) begin
                  errors++;
                  $display("FAIL psg_write_data: actual 0x%0h required 0x%0h", psg_data, cur_data);
               end
            end
            writes_seen++;
            in_low  = 1'b1;
            low_ce  = 0;
            low_cyc = 0;
         end
         if (!psg_wr_n) begin
            low_cyc++;
            if (psg_ce) low_ce++;
         end
         if (!prev_wr && psg_wr_n && in_low) begin
            check("wr_low_ce", low_ce, WR_LOW);
            check("wr_low_cycles_63_65", (low_cyc >= 63 && low_cyc <= 65), 1);
            check("data_held", psg_data, cur_data);
            in_low    = 1'b0;
            have_prev = 1'b1;
            gap_ce    = 0;
         end
         if (psg_wr_n && have_prev && psg_ce) gap_ce++;
         prev_wr = psg_wr_n;
      end
   end

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy || !fifo_empty || !psg_wr_n) && n < 4000) begin
         @(negedge clk_sys);
         n++;
      end
      check(name, (n < 4000), 1);
   endtask

   task automatic do_reset(input int cycles);
      @(posedge clk_sys);
      #1 reset = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk_sys);
         #1 stb_n = (i % 2 == 0) ? 1'b0 : 1'b1;
         data_in = 8'(i + 8'h11);
      end
      stb_n = 1'b1;
      @(posedge clk_sys);
      #1 reset = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] d);
      @(posedge clk_sys);
      #1 stb_n = 1'b0;
      data_in = d;
      exp_q.push_back(d);
      @(posedge clk_sys);
      @(posedge clk_sys);
      #1 stb_n = 1'b1;
      @(posedge clk_sys);
   endtask

   initial begin
      int w0;
      int n;
      burst[0] = '{8'h80, 1'b1, 1'b0, 1'b0};
      burst[1] = '{8'h81, 1'b1, 1'b0, 1'b0};
      burst[2] = '{8'h82, 1'b1, 1'b0, 1'b0};
      burst[3] = '{8'h83, 1'b1, 1'b0, 1'b0};
      burst[4] = '{8'h84, 1'b1, 1'b1, 1'b0};
      burst[5] = '{8'h85, 1'b0, 1'b1, 1'b1};

      // Reset with stb_n toggling
      do_reset(3);
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("rst_wr_n", psg_wr_n, 1);
      check("rst_data", psg_data, 8'h00);
      check("rst_clk_en", psg_clk_en, 0);
      check("rst_empty", fifo_empty, 1);
      check("rst_full", fifo_full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_busy", busy, 0);

      // Single write latency
      @(posedge clk_sys);
      #1 stb_n = 1'b0;
      data_in = 8'h9F;
      exp_q.push_back(8'h9F);
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("lat_n_clk_en", psg_clk_en, 1);
      check("lat_n_empty", fifo_empty, 0);
      check("lat_n_wr_n", psg_wr_n, 1);
      stb_n = 1'b1;
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("lat_n1_data", psg_data, 8'h00);
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("lat_n2_data", psg_data, 8'h9F);
      check("lat_n2_wr_n", psg_wr_n, 1);
      check("lat_n2_busy", busy, 1);
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("lat_n3_wr_n", psg_wr_n, 0);
      drain("single_drain");
      check("single_busy_after", busy, 0);

      // Burst: table of pushes four cycles apart
      for (int i = 0; i < 6; i++) begin
         @(posedge clk_sys);
         #1 stb_n = 1'b0;
         data_in = burst[i].data;
         if (burst[i].exp_accept) exp_q.push_back(burst[i].data);
         @(posedge clk_sys);
         @(negedge clk_sys);
         check($sformatf("burst%0d_full", i), fifo_full, burst[i].exp_full);
         check($sformatf("burst%0d_ovf", i), overflow, burst[i].exp_ovf);
         @(posedge clk_sys);
         #1 stb_n = 1'b1;
         @(posedge clk_sys);
      end
      drain("burst_drain");
      check("burst_ovf_sticky", overflow, 1);

      // Long strobe yields one write
      w0 = writes_seen;
      @(posedge clk_sys);
      #1 stb_n = 1'b0;
      data_in = 8'h3C;
      exp_q.push_back(8'h3C);
      repeat (50) @(posedge clk_sys);
      #1 stb_n = 1'b1;
      drain("long_drain");
      check("long_write_count", writes_seen - w0, 1);

      // Full FIFO with push in the pop cycle
      do_reset(2);
      push_byte(8'hA0);
      push_byte(8'hA1);
      push_byte(8'hA2);
      push_byte(8'hA3);
      push_byte(8'hA4);
      @(negedge clk_sys);
      check("fp_full_before", fifo_full, 1);
      n = 0;
      while (busy && n < 1000) begin
         @(negedge clk_sys);
         n++;
      end
      check("fp_idle_wait", (n < 1000), 1);
      stb_n = 1'b0;
      data_in = 8'hF5;
      exp_q.push_back(8'hF5);
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("fp_full_kept", fifo_full, 1);
      check("fp_ovf_zero", overflow, 0);
      check("fp_popped", busy, 1);
      stb_n = 1'b1;
      drain("fp_drain");
      check("fp_ovf_end", overflow, 0);

      // Reset in the middle of STROBE
      push_byte(8'h55);
      n = 0;
      while (psg_wr_n && n < 100) begin
         @(negedge clk_sys);
         n++;
      end
      check("mid_strobe_reached", (n < 100), 1);
      repeat (10) @(posedge clk_sys);
      #1 reset = 1'b1;
      @(posedge clk_sys);
      @(negedge clk_sys);
      check("mid_rst_wr_n", psg_wr_n, 1);
      check("mid_rst_empty", fifo_empty, 1);
      check("mid_rst_clk_en", psg_clk_en, 0);
      check("mid_rst_busy", busy, 0);
      @(posedge clk_sys);
      #1 reset = 1'b0;
      w0 = writes_seen;
      push_byte(8'h6A);
      drain("post_rst_drain");
      check("post_rst_writes", writes_seen - w0, 1);
      check("post_rst_clk_en", psg_clk_en, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/melodik_wr_sequencer.md
Name: melodik_wr_sequencer

Overview:
- Sits between the Ondra core parallel port (Parallel_Data_OUT / NON_STB) and the sn76489_audio instance in the top level.
- Queues CPU writes to the Melodik PSG in a small FIFO and replays each one to the PSG with a guaranteed wr_n low width and inter-write gap, both counted in PSG clock-enable ticks.
- Replaces the asynchronous NON_STB-clocked enable flip-flop with a synchronous PSG clock gate.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- WR_LOW_TICKS, 32: psg_ce pulses during which psg_wr_n is held low per write; minimum 1.
- GAP_TICKS, 4: psg_ce pulses with psg_wr_n high after each write before the next pop; minimum 1.

Ports:
- clk_sys  in  1  system clock, 8 MHz.
- reset  in  1  synchronous, active-high.
- psg_ce  in  1  4 MHz enable pulse, synchronous to clk_sys (one clk_sys cycle wide).
- stb_n  in  1  NON_STB from core; active low; synchronous to clk_sys.
- data_in  in  8  Parallel_Data_OUT.
- psg_wr_n  out  1  to sn76489 wr_n_i.
- psg_data  out  8  to sn76489 data_i.
- psg_clk_en  out  1  gate; top level drives en_clk_psg_i = psg_ce & psg_clk_en.
- fifo_full  out  1  FIFO holds DEPTH entries.
- fifo_empty  out  1  FIFO holds 0 entries.
- overflow  out  1  sticky; a write was dropped.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (synchronous): psg_wr_n=1, psg_data=0x00, psg_clk_en=0, fifo_full=0, fifo_empty=1, overflow=0, busy=0, stb_n_q=1, FIFO flushed, FSM=IDLE, tick counter=0.
- Reset mid-operation: psg_wr_n returns to 1 at that edge and any partially strobed write is abandoned.
- Strobe detection:
  - stb_n_q is stb_n registered.
  - push = stb_n_q & ~stb_n, so exactly one push per falling edge regardless of low duration.
  - data_in is sampled at that edge.
- Push:
  - Accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle (simultaneous push/pop on full is accepted).
  - Otherwise the byte is dropped and overflow is set to 1 until reset.
  - The first accepted push sets psg_clk_en=1; it stays 1 until reset.
- Count: count' = count + push_accepted - pop, width clog2(DEPTH)+1. fifo_full = (count==DEPTH); fifo_empty = (count==0). Both are registered and update on the same edge as count.
- Pointers: wrap modulo DEPTH.
- FSM states: IDLE, SETUP, STROBE, GAP.
  - IDLE: if !fifo_empty, pop; psg_data<=head; go to SETUP. A push arriving into an empty FIFO is not visible to IDLE until the next cycle, so there is no same-cycle bypass.
  - SETUP: one clk_sys cycle, psg_wr_n=1, psg_data stable. Next state STROBE with psg_wr_n<=0 and tick counter=0.
  - STROBE: psg_wr_n=0; counter increments on each psg_ce. On the psg_ce that makes the counter reach WR_LOW_TICKS, set psg_wr_n<=1, clear the counter, go to GAP.
  - GAP: psg_wr_n=1, psg_data held. On the psg_ce that makes the counter reach GAP_TICKS, go to IDLE.
- psg_data changes only on a pop. It is stable from SETUP through the end of GAP.
- Latency: stb_n first sampled low at edge N (push). With the FIFO empty and the FSM in IDLE:
  - psg_data valid after edge N+2 (pop).
  - psg_wr_n=0 after edge N+3.
- psg_ce arriving during IDLE or SETUP is ignored.
- Pushes continue to be accepted while the FSM is busy.

Test Plan:
- Reset: hold reset 3 cycles with stb_n toggling -> psg_wr_n=1, psg_clk_en=0, fifo_empty=1, overflow=0, no pushes recorded.
- Single write, psg_ce every 2nd cycle: stb_n low at edge N with data_in=0x9F -> psg_clk_en=1 after N; psg_data=0x9F after N+2; psg_wr_n=0 after N+3 for exactly 32 psg_ce pulses (64±1 clk_sys); then ≥4 psg_ce with wr_n high; busy=0 afterwards.
- Burst: 6 stb_n pulses 4 cycles apart, data 0x80..0x85, DEPTH=4 -> 0x80 popped first, 0x81–0x84 fill the FIFO (fifo_full=1), 0x85 dropped with overflow=1; PSG receives 0x80..0x84 in order, each with a full wr_n pulse.
- Long strobe: stb_n held low 50 cycles with data 0x3C -> exactly one PSG write of 0x3C.
- Full plus pop: FIFO full, FSM entering IDLE, stb_n falling edge in the pop cycle -> push accepted, count stays DEPTH, overflow stays 0.
- Reset mid-strobe: assert reset 10 cycles into STROBE -> psg_wr_n=1 on that edge, FIFO empty, psg_clk_en=0; a subsequent write proceeds normally.
